score_text_fmt: RTL and testbench
=================================

# score_text_fmt

Converts a binary game value (score, ammo count, round number) into two 7-bit ASCII decimal digits and delivers them as one two-character write burst on the `load_text`/`text` interface consumed by the on-screen character RAM. The block is the writer side of that interface. It sits between game-control logic, which produces the value and a start strobe, and the text-display path. Conversion uses an iterative divide-by-10 (repeated subtraction), so the block is small and spends one cycle per tens digit.

## Interface
Parameters:
- `BLANK_LEADING_ZERO`, default 1: when 1, a tens digit of 0 is emitted as ASCII space (7'h20); when 0, it is emitted as '0' (7'h30).

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `value_in`  in  7: unsigned value to display, range 0–127.
- `value_valid`  in  1: start strobe; sampled only in IDLE.
- `busy`  out  1: high while a conversion is in progress (state ≠ IDLE).
- `load_text`  out  1: one-cycle write strobe to the character RAM.
- `text_out`  out  14: `[13:7]` = first character (tens), `[6:0]` = second character (units). Stable while `load_text` is high and held until the next load.

## Operation
- States: IDLE, DIV.
- **IDLE**
  - If `value_valid`=1: capture `rem <= min(value_in, 99)` (values 100–127 clamp to 99) and set `tens <= 0`. Next state is DIV.
  - Otherwise remain in IDLE.
- **DIV**, one step per cycle:
  - If `rem >= 10`: `rem <= rem - 10`, `tens <= tens + 1`. Stay in DIV.
  - Else:
    - `text_out[6:0] <= 7'h30 + rem`.
    - `text_out[13:7] <= (tens==0 && BLANK_LEADING_ZERO) ? 7'h20 : 7'h30 + tens`.
    - `load_text <= 1`, next state is IDLE.
- `load_text` is high for exactly one cycle. In every cycle where it is not explicitly set, it is cleared.
- Widths:
  - `rem` is 7 bits.
  - `tens` is 4 bits; its maximum is 9, so it never overflows.
  - Digit addition is 7-bit, with no carry beyond 7'h39.
- `value_valid` while `busy`=1 is ignored. It is not queued and has no effect on the conversion in progress.
- `value_in` changes after the capture cycle do not affect the conversion in progress.
- `value_valid` in the same cycle that `load_text` is high (state already IDLE) is accepted: a new conversion starts. The next `load_text` follows after the normal latency.
- `rst` asserted in any state:
  - Next cycle: state=IDLE, `busy`=0, `load_text`=0, `text_out`=14'h1020 (two spaces: `{7'h20,7'h20}`), `rem`=0, `tens`=0.
  - A conversion aborted by reset produces no `load_text` pulse.
- `rst` has priority over `value_valid` in the same cycle.

## Timing
- Reset values: `busy`=0, `load_text`=0, `text_out`=`{7'h20,7'h20}`.
- Let T = tens digit of the clamped value (0–9), and let `value_valid` be sampled in IDLE at edge N.
  - `busy` is high from edge N+1 through edge N+1+T.
  - `load_text`=1 and the new `text_out` are visible in cycle N+2+T, and `busy`=0 in that same cycle.
- Latency: T+2 cycles (minimum 2 for values 0–9, maximum 11 for 90–127).
- Throughput: one conversion every T+2 cycles when `value_valid` is held high.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then drive `value_in`=0 with `value_valid`=1 for 1 cycle (`BLANK_LEADING_ZERO`=1) -> `load_text` pulses 2 cycles later for exactly 1 cycle; `text_out`=`{7'h20,7'h30}` (" 0").
- `value_in`=57 -> `busy` high for 6 cycles; `load_text` at +7; `text_out`=`{7'h35,7'h37}`. Then `value_in`=99 -> `load_text` at +11 with `{7'h39,7'h39}`. Then `value_in`=120 -> identical to the 99 case (clamp).
- `BLANK_LEADING_ZERO`=0, `value_in`=7 -> `text_out`=`{7'h30,7'h37}` ("07"); with the parameter at 1 -> `{7'h20,7'h37}`.
- Start a conversion of 42, pulse `value_valid` with 13 during `busy`, and change `value_in` mid-conversion -> exactly one `load_text`, with `{7'h34,7'h32}`; no second pulse.
- Hold `value_valid`=1 with `value_in`=10 -> `load_text` every 3 cycles, each carrying `{7'h31,7'h30}`.
- Start a conversion of 80, assert `rst` 4 cycles later -> no `load_text` pulse; `busy`=0 and `text_out`=`{7'h20,7'h20}` on the next cycle. A subsequent start with 5 completes normally in 2 cycles.

Source files
------------

// File: rtl/score_text_fmt.sv
// Binary-to-two-digit ASCII formatter: clamps a 7-bit value to 0..99, divides by
// repeated subtraction of 10, then emits both characters in one load_text strobe.
module score_text_fmt #(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic        load_text,
  output logic [13:0] text_out
);

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  localparam logic [6:0]  CHAR_SPACE = 7'h20;
  localparam logic [6:0]  CHAR_ZERO  = 7'h30;
  localparam logic [13:0] TEXT_BLANK = {CHAR_SPACE, CHAR_SPACE};

  state_t       state_reg, state_next;
  logic [6:0]   rem_reg, rem_next;
  logic [3:0]   tens_reg, tens_next;
  logic [13:0]  text_reg, text_next;
  logic         load_reg, load_next;
  logic [6:0]   tens_char;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= 7'd0;
      tens_reg  <= 4'd0;
      text_reg  <= TEXT_BLANK;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      tens_reg  <= tens_next;
      text_reg  <= text_next;
      load_reg  <= load_next;
    end
  end

  // A zero tens digit is optionally blanked so single-digit values read " 7".
  always_comb begin
    if ((tens_reg == 4'd0) && BLANK_LEADING_ZERO)
      tens_char = CHAR_SPACE;
    else
      tens_char = CHAR_ZERO + {3'b000, tens_reg};
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    tens_next  = tens_reg;
    text_next  = text_reg;
    load_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (value_valid) begin
          rem_next   = (value_in > 7'd99) ? 7'd99 : value_in;
          tens_next  = 4'd0;
          state_next = DIV;
        end
      end
      DIV: begin
        if (rem_reg >= 7'd10) begin
          rem_next  = rem_reg - 7'd10;
          tens_next = tens_reg + 4'd1;
        end else begin
          text_next  = {tens_char, CHAR_ZERO + rem_reg};
          load_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign load_text = load_reg;
  assign text_out  = text_reg;

endmodule

// File: tb/tb_score_text_fmt.sv
// Directed and random checks of score_text_fmt against a digit-arithmetic model,
// with one instance blanking the leading zero and one printing it.
module tb_score_text_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  value_in;
  logic        value_valid;
  logic        busy_b, load_b, busy_z, load_z;
  logic [13:0] text_b, text_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_text_fmt #(.BLANK_LEADING_ZERO(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_b), .load_text(load_b), .text_out(text_b)
  );

  score_text_fmt #(.BLANK_LEADING_ZERO(1'b0)) dut_zero (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_z), .load_text(load_z), .text_out(text_z)
  );

  function automatic int clamp99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [13:0] model_text(input int v, input bit blank);
    int c, t, u;
    logic [6:0] hi, lo;
    c  = clamp99(v);
    t  = c / 10;
    u  = c % 10;
    hi = (t == 0 && blank) ? 7'h20 : 7'(48 + t);
    lo = 7'(48 + u);
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion and verifies latency, busy length, both texts and pulse width.
  task automatic convert(input int v);
    int lat, busy_cnt, t;
    bit got;
    t = clamp99(v) / 10;
    @(negedge clk);
    value_in    = 7'(v);
    value_valid = 1'b1;
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      value_valid = 1'b0;
      lat++;
      if (busy_b) busy_cnt++;
      if (load_b) got = 1;
    end
    check($sformatf("load_seen v=%0d", v), 32'(got), 32'd1);
    check($sformatf("latency v=%0d", v), 32'(lat), 32'(t + 2));
    check($sformatf("busy_cycles v=%0d", v), 32'(busy_cnt), 32'(t + 1));
    check($sformatf("busy_at_load v=%0d", v), 32'(busy_b), 32'd0);
    check($sformatf("load_zero_inst v=%0d", v), 32'(load_z), 32'd1);
    check($sformatf("text_blank v=%0d", v), 32'(text_b), 32'(model_text(v, 1'b1)));
    check($sformatf("text_zero v=%0d", v), 32'(text_z), 32'(model_text(v, 1'b0)));
    @(negedge clk);
    check($sformatf("load_one_cycle v=%0d", v), 32'(load_b), 32'd0);
    $display("conv value=%0d latency=%0d text_blank=%h text_zero=%h", v, lat, text_b, text_z);
  endtask

  initial begin
    int loads, since, gaps_bad, wait_cnt;
    rst = 1'b1; value_in = 7'd0; value_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy_b), 32'd0);
    check("reset_load", 32'(load_b), 32'd0);
    check("reset_text", 32'(text_b), 32'h1020);
    check("reset_text_zero_inst", 32'(text_z), 32'h1020);
    rst = 1'b0;

    // Directed corner values, including the clamp range.
    convert(0);
    convert(57);
    convert(99);
    convert(120);
    convert(7);
    convert(9);
    convert(10);
    convert(127);
    convert(100);

    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 127)));

    // Start 42, then a stray strobe with 13 and a value change while busy.
    @(negedge clk);
    value_in = 7'd42; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    @(negedge clk);
    value_in = 7'd13; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0; value_in = 7'd100;
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_b) begin
        loads++;
        check("ignore_busy_text", 32'(text_b), 32'(model_text(42, 1'b1)));
      end
      @(negedge clk);
    end
    check("ignore_busy_loads", 32'(loads), 32'd1);
    $display("ignore-while-busy loads=%0d text=%h", loads, text_b);

    // Held strobe with 10: a load every third cycle.
    @(negedge clk);
    value_in = 7'd10; value_valid = 1'b1;
    loads = 0; since = 0; gaps_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      since++;
      if (load_b) begin
        if (loads > 0 && since != 3) gaps_bad++;
        loads++;
        since = 0;
        check("held_text", 32'(text_b), 32'(model_text(10, 1'b1)));
      end
    end
    check("held_load_count", 32'(loads), 32'd5);
    check("held_gap_errors", 32'(gaps_bad), 32'd0);
    $display("held-valid loads=%0d gap_errors=%0d", loads, gaps_bad);
    value_valid = 1'b0;
    wait_cnt = 0;
    while ((busy_b || load_b) && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_idle", 32'(busy_b), 32'd0);

    // Abort a conversion of 80 with reset.
    @(negedge clk);
    value_in = 7'd80; value_valid = 1'b1;
    loads = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      value_valid = 1'b0;
      if (load_b) loads++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy_b), 32'd0);
    check("abort_load", 32'(load_b), 32'd0);
    check("abort_text", 32'(text_b), 32'h1020);
    for (int i = 0; i < 12; i++) begin
      if (load_b) loads++;
      @(negedge clk);
    end
    check("abort_no_load", 32'(loads), 32'd0);
    $display("reset-abort loads=%0d text=%h", loads, text_b);
    convert(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
